// File: rtl/exec_pkg.sv
// Shared types and ALU helper for the register-file execute stage.
// Optional multiplier is enabled with EXEC_MUL_EN.
package exec_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 4;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_AND   = 4'h2,
        OP_OR    = 4'h3,
        OP_XOR   = 4'h4,
        OP_SLL   = 4'h5,
        OP_SRL   = 4'h6,
        OP_SRA   = 4'h7,
        OP_SLT   = 4'h8,
        OP_SLTU  = 4'h9,
        OP_PASSA = 4'hA,
        OP_PASSB = 4'hB,
        OP_MUL   = 4'hC
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        MUL_RUN,
        MUL_HOLD
    } exec_state_e;

    // Returns {err, data}; anything not handled here (incl. MUL) is illegal.
    function automatic logic [XLEN:0] alu_f(
        input logic [3:0]      op,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [XLEN-1:0] r;
        logic            e;
        r = '0;
        e = 1'b0;
        case (op)
            OP_ADD:   r = a + b;
            OP_SUB:   r = a - b;
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_SLL:   r = a << b[4:0];
            OP_SRL:   r = a >> b[4:0];
            OP_SRA:   r = $signed(a) >>> b[4:0];
            OP_SLT:   r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU:  r = {{(XLEN-1){1'b0}}, a < b};
            OP_PASSA: r = a;
            OP_PASSB: r = b;
            default:  e = 1'b1;
        endcase
        return {e, r};
    endfunction

endpackage

// File: rtl/exec_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle.
// done_o stays high with the product until the next start.
module exec_mul_seq
    import exec_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] prod_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] acc_q;
    logic [CW-1:0]   cnt_q;
    logic            run_q;
    logic            done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (start_i) begin
            a_q    <= a_i;
            b_q    <= b_i;
            acc_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b1;
            done_q <= 1'b0;
        end else if (run_q) begin
            if (b_q[cnt_q])
                acc_q <= acc_q + (a_q << cnt_q);
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                run_q  <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    assign done_o = done_q;
    assign prod_o = acc_q;

endmodule

// File: rtl/regfile_exec_stage.sv
// Execute stage feeding the register file write port via a one-deep slot.
// Define EXEC_MUL_EN to build the iterative multiplier for opcode C.
module regfile_exec_stage
    import exec_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [XLEN-1:0]   in_a,
    input  logic [XLEN-1:0]   in_b,
    input  logic [REG_AW-1:0] in_dst,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [XLEN-1:0]   wb_data,
    output logic [REG_AW-1:0] wb_sel,
    output logic              wb_err
);

    logic              wb_valid_q;
    logic [XLEN-1:0]   wb_data_q;
    logic [REG_AW-1:0] wb_sel_q;
    logic              wb_err_q;

    logic              slot_free;
    logic              accept;
    logic [XLEN:0]     alu_res;

    logic              ld;
    logic [XLEN-1:0]   ld_data;
    logic [REG_AW-1:0] ld_sel;
    logic              ld_err;

    assign slot_free = !wb_valid_q || wb_ready;
    assign accept    = in_valid && in_ready;
    assign alu_res   = alu_f(in_op, in_a, in_b);

`ifdef EXEC_MUL_EN
    exec_state_e       state_q;
    exec_state_e       state_d;
    logic [REG_AW-1:0] mdst_q;
    logic              mul_start;
    logic              mul_done;
    logic [XLEN-1:0]   mul_prod;

    assign in_ready  = (state_q == IDLE) && slot_free;
    assign mul_start = accept && (in_op == OP_MUL);

    exec_mul_seq u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (mul_start),
        .a_i     (in_a),
        .b_i     (in_b),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );
`else
    assign in_ready = slot_free;
`endif

    always_comb begin
        ld      = accept;
        ld_data = alu_res[XLEN-1:0];
        ld_err  = alu_res[XLEN];
        ld_sel  = in_dst;
`ifdef EXEC_MUL_EN
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (mul_start) begin
                    ld      = 1'b0;
                    state_d = MUL_RUN;
                end
            end
            MUL_RUN: begin
                if (mul_done)
                    state_d = slot_free ? IDLE : MUL_HOLD;
                ld = mul_done && slot_free;
            end
            MUL_HOLD: begin
                if (slot_free)
                    state_d = IDLE;
                ld = slot_free;
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE) begin
            ld_data = mul_prod;
            ld_err  = 1'b0;
            ld_sel  = mdst_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_sel_q   <= '0;
            wb_err_q   <= 1'b0;
`ifdef EXEC_MUL_EN
            state_q    <= IDLE;
            mdst_q     <= '0;
`endif
        end else begin
            if (ld) begin
                wb_valid_q <= 1'b1;
                wb_data_q  <= ld_data;
                wb_sel_q   <= ld_sel;
                wb_err_q   <= ld_err;
            end else if (wb_ready) begin
                wb_valid_q <= 1'b0;
            end
`ifdef EXEC_MUL_EN
            state_q <= state_d;
            if (mul_start)
                mdst_q <= in_dst;
`endif
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_data  = wb_data_q;
    assign wb_sel   = wb_sel_q;
    assign wb_err   = wb_err_q;

endmodule

// File: tb/tb_regfile_exec_stage.sv
// Directed bench for regfile_exec_stage: vector table plus
// backpressure, multiply and mid-operation reset sequences.
module tb_regfile_exec_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_dst;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [3:0]  wb_sel;
    logic        wb_err;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  dst;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    regfile_exec_stage dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_dst   (in_dst),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_data  (wb_data),
        .wb_sel   (wb_sel),
        .wb_err   (wb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] dst);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_dst   = dst;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int bad;
        vecs.push_back('{4'h0, 32'habcd_efab, 32'h0123_4567, 4'd0, 32'hacf1_3512, 1'b0});
        vecs.push_back('{4'h1, 32'd5, 32'd7, 4'd1, 32'hffff_fffe, 1'b0});
        vecs.push_back('{4'h7, 32'h8000_0000, 32'd4, 4'd2, 32'hf800_0000, 1'b0});
        vecs.push_back('{4'h2, 32'hff00_ff00, 32'h0f0f_0f0f, 4'd4, 32'h0f00_0f00, 1'b0});
        vecs.push_back('{4'h3, 32'h1234_0000, 32'h0000_5678, 4'd6, 32'h1234_5678, 1'b0});
        vecs.push_back('{4'h4, 32'hffff_ffff, 32'h0000_ffff, 4'd7, 32'hffff_0000, 1'b0});
        vecs.push_back('{4'h5, 32'd1, 32'h0000_001f, 4'd8, 32'h8000_0000, 1'b0});
        vecs.push_back('{4'h5, 32'd3, 32'h0000_0021, 4'd9, 32'h0000_0006, 1'b0});
        vecs.push_back('{4'h6, 32'h8000_0000, 32'd4, 4'd10, 32'h0800_0000, 1'b0});
        vecs.push_back('{4'h8, 32'hffff_ffff, 32'd1, 4'd11, 32'd1, 1'b0});
        vecs.push_back('{4'h9, 32'hffff_ffff, 32'd1, 4'd12, 32'd0, 1'b0});
        vecs.push_back('{4'hA, 32'hdead_beef, 32'd9, 4'd13, 32'hdead_beef, 1'b0});
        vecs.push_back('{4'hB, 32'd9, 32'hcafe_f00d, 4'd14, 32'hcafe_f00d, 1'b0});
        vecs.push_back('{4'h0, 32'hffff_ffff, 32'd1, 4'd15, 32'd0, 1'b0});
        vecs.push_back('{4'hE, 32'd1, 32'd2, 4'd5, 32'd0, 1'b1});
        vecs.push_back('{4'hD, 32'd3, 32'd4, 4'd3, 32'd0, 1'b1});
        vecs.push_back('{4'hF, 32'd5, 32'd6, 4'd2, 32'd0, 1'b1});

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_op    = '0;
        in_a     = '0;
        in_b     = '0;
        in_dst   = '0;
        wb_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_sel", 32'(wb_sel), 32'd0);
        check("rst_wb_err", 32'(wb_err), 32'd0);
        rst_n = 1'b1;
        cycle();
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back table walk with the consumer always ready.
        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dst);
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
            cycle();
            check($sformatf("v%0d_valid", i), 32'(wb_valid), 32'd1);
            check($sformatf("v%0d_data", i), wb_data, vecs[i].exp);
            check($sformatf("v%0d_sel", i), 32'(wb_sel), 32'(vecs[i].dst));
            check($sformatf("v%0d_err", i), 32'(wb_err), 32'(vecs[i].err));
        end
        in_valid = 1'b0;
        cycle();
        check("idle_valid", 32'(wb_valid), 32'd0);

        // Backpressure: the held beat must stay put.
        wb_ready = 1'b0;
        drive(4'h0, 32'd10, 32'd20, 4'd3);
        cycle();
        in_valid = 1'b0;
        check("bp_valid0", 32'(wb_valid), 32'd1);
        check("bp_data0", wb_data, 32'd30);
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            if (wb_valid !== 1'b1 || wb_data !== 32'd30 ||
                wb_sel !== 4'd3 || in_ready !== 1'b0)
                bad++;
        end
        check("bp_hold", 32'(bad), 32'd0);
        wb_ready = 1'b1;
        cycle();
        check("bp_retired", 32'(wb_valid), 32'd0);
        check("bp_in_ready", 32'(in_ready), 32'd1);

        // Multiply 0x1234 * 0x10.
        drive(4'hC, 32'h0000_1234, 32'h0000_0010, 4'd3);
        cycle();
        in_valid = 1'b0;
`ifdef EXEC_MUL_EN
        bad = 0;
        for (int k = 0; k < 33; k++) begin
            if (wb_valid !== 1'b0 || in_ready !== 1'b0)
                bad++;
            if (k < 32)
                cycle();
        end
        check("mul_busy", 32'(bad), 32'd0);
        cycle();
        check("mul_valid", 32'(wb_valid), 32'd1);
        check("mul_data", wb_data, 32'h0001_2340);
        check("mul_sel", 32'(wb_sel), 32'd3);
        check("mul_err", 32'(wb_err), 32'd0);
`else
        check("mul_valid", 32'(wb_valid), 32'd1);
        check("mul_data", wb_data, 32'd0);
        check("mul_sel", 32'(wb_sel), 32'd3);
        check("mul_err", 32'(wb_err), 32'd1);
`endif
        cycle();
        check("mul_retired", 32'(wb_valid), 32'd0);

        // Reset in the middle of work: a MUL in flight, or a held beat.
`ifdef EXEC_MUL_EN
        drive(4'hC, 32'd7, 32'd9, 4'd6);
`else
        wb_ready = 1'b0;
        drive(4'h0, 32'd7, 32'd9, 4'd6);
`endif
        cycle();
        in_valid = 1'b0;
        repeat (10) cycle();
        rst_n = 1'b0;
        #1;
        check("mrst_valid", 32'(wb_valid), 32'd0);
        check("mrst_data", wb_data, 32'd0);
        check("mrst_sel", 32'(wb_sel), 32'd0);
        wb_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (wb_valid !== 1'b0)
                bad++;
        end
        check("mrst_no_wb", 32'(bad), 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        drive(4'h0, 32'd1, 32'd1, 4'd4);
        cycle();
        in_valid = 1'b0;
        check("post_valid", 32'(wb_valid), 32'd1);
        check("post_data", wb_data, 32'd2);
        check("post_sel", 32'(wb_sel), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
